// File: rtl/n2r_pkg.sv
// Shared types and sizing helpers for the n2r weight-row packer.
// The optional tlast checker is enabled by defining N2R_TLAST_CHECK_EN.
package n2r_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int beats_per_row(input int width, input int col, input int in_width);
    return (width * col) / in_width;
  endfunction

  // Counter width for a 0..n-1 counter, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/n2r_row_bank.sv
// One full-row register built from IN_WIDTH-bit slots; slot 0 lands in the row MSBs.
module n2r_row_bank
  import n2r_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int COL      = 64,
  parameter int IN_WIDTH = 64,
  localparam int BEATS    = beats_per_row(WIDTH, COL, IN_WIDTH),
  localparam int SLOT_W   = cnt_width(BEATS),
  localparam int ROW_BITS = WIDTH * COL
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [SLOT_W-1:0]   slot,
  input  logic [IN_WIDTH-1:0] data,
  output logic [ROW_BITS-1:0] row
);

  logic [IN_WIDTH-1:0] slots [BEATS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BEATS; i++) slots[i] <= '0;
    end else if (we) begin
      slots[slot] <= data;
    end
  end

  for (genvar g = 0; g < BEATS; g++) begin : g_slot
    assign row[ROW_BITS-1-g*IN_WIDTH -: IN_WIDTH] = slots[g];
  end

endmodule

// File: rtl/n2r_packer_w.sv
// Packs a narrow row-major beat stream into full weight rows through two ping-pong banks.
// Define N2R_TLAST_CHECK_EN to build the sticky tlast-mismatch checker.
module n2r_packer_w
  import n2r_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int COL      = 64,
  parameter int ROW      = 256,
  parameter int IN_WIDTH = 64,
  localparam int BEATS_PER_ROW = beats_per_row(WIDTH, COL, IN_WIDTH),
  localparam int ROW_BITS      = WIDTH * COL,
  localparam int BEAT_W        = cnt_width(BEATS_PER_ROW),
  localparam int IDX_W         = cnt_width(ROW)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [IN_WIDTH-1:0] s_tdata,
  input  logic                s_tvalid,
  output logic                s_tready,
  input  logic                s_tlast,
  output logic [ROW_BITS-1:0] out_row,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [IDX_W-1:0]    out_row_idx,
  output logic                matrix_done,
  output logic                err_tlast,
  output logic [1:0]          state_dbg
);

  // Handshake: a transfer happens on a rising clk edge where valid && ready;
  // valid never waits on ready, and data/idx hold steady while valid && !ready.

  state_t              state, state_nx;
  logic [1:0]          full, full_nx;
  logic                wr_bank, rd_bank;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [IDX_W-1:0]    in_row_cnt, out_row_cnt;
  logic                in_done;
  logic                accept, row_last_beat, handoff, final_handoff, arm;
  logic [ROW_BITS-1:0] bank_row [2];

  assign s_tready      = (state == ST_RUN) && !full[wr_bank] && !in_done;
  assign accept        = s_tvalid && s_tready;
  assign row_last_beat = accept && (beat_cnt == BEAT_W'(BEATS_PER_ROW - 1));
  assign out_valid     = full[rd_bank];
  assign handoff       = out_valid && out_ready;
  assign final_handoff = handoff && (out_row_cnt == IDX_W'(ROW - 1));
  assign arm           = start && (state != ST_RUN);

  assign out_row     = rd_bank ? bank_row[1] : bank_row[0];
  assign out_row_idx = out_row_cnt;
  assign state_dbg   = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_nx = ST_RUN;
      ST_RUN:           if (final_handoff) state_nx = ST_DONE;
      default:          state_nx = ST_IDLE;
    endcase
  end

  // Fill of one bank and drain of the other can land in the same cycle.
  always_comb begin
    full_nx = full;
    if (row_last_beat) full_nx[wr_bank] = 1'b1;
    if (handoff)       full_nx[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full        <= '0;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      beat_cnt    <= '0;
      in_row_cnt  <= '0;
      out_row_cnt <= '0;
      in_done     <= 1'b0;
      matrix_done <= 1'b0;
    end else if (arm) begin
      full        <= '0;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      beat_cnt    <= '0;
      in_row_cnt  <= '0;
      out_row_cnt <= '0;
      in_done     <= 1'b0;
      matrix_done <= 1'b0;
    end else begin
      full <= full_nx;
      if (accept) begin
        if (row_last_beat) begin
          beat_cnt   <= '0;
          wr_bank    <= ~wr_bank;
          in_row_cnt <= in_row_cnt + 1'b1;
          if (in_row_cnt == IDX_W'(ROW - 1)) in_done <= 1'b1;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
      if (handoff) begin
        rd_bank     <= ~rd_bank;
        out_row_cnt <= out_row_cnt + 1'b1;
      end
      if (final_handoff) matrix_done <= 1'b1;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    n2r_row_bank #(
      .WIDTH    (WIDTH),
      .COL      (COL),
      .IN_WIDTH (IN_WIDTH)
    ) u_bank (
      .clk  (clk),
      .rst  (rst),
      .we   (accept && (wr_bank == 1'(b))),
      .slot (beat_cnt),
      .data (s_tdata),
      .row  (bank_row[b])
    );
  end

`ifdef N2R_TLAST_CHECK_EN
  logic exp_tlast;
  assign exp_tlast = (in_row_cnt == IDX_W'(ROW - 1)) &&
                     (beat_cnt == BEAT_W'(BEATS_PER_ROW - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  err_tlast <= 1'b0;
    else if (arm)                             err_tlast <= 1'b0;
    else if (accept && (s_tlast != exp_tlast)) err_tlast <= 1'b1;
  end
`else
  logic unused_tlast;
  assign unused_tlast = s_tlast;
  assign err_tlast    = 1'b0;
`endif

endmodule

// File: tb/tb_n2r_packer_w.sv
// Self-checking bench for n2r_packer_w: scenario table, random traffic against a packing model,
// plus hand-written backpressure, tlast and mid-matrix reset sequences.
module tb_n2r_packer_w;

  localparam int W     = 16;
  localparam int C     = 64;
  localparam int R     = 256;
  localparam int IW    = 64;
  localparam int BPR   = (W * C) / IW;
  localparam int EPB   = IW / W;
  localparam int RB    = W * C;
  localparam int NB    = R * BPR;
  localparam int LIMIT = 30000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [IW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          out_ready = 1'b0;
  logic          s_tready, out_valid, matrix_done, err_tlast;
  logic [RB-1:0] out_row;
  logic [7:0]    out_row_idx;
  logic [1:0]    state_dbg;

  n2r_packer_w #(.WIDTH(W), .COL(C), .ROW(R), .IN_WIDTH(IW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .s_tdata     (s_tdata),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .s_tlast     (s_tlast),
    .out_row     (out_row),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_row_idx (out_row_idx),
    .matrix_done (matrix_done),
    .err_tlast   (err_tlast),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [IW-1:0] mem [NB];
  logic [RB-1:0] exp_q[$];

`ifdef N2R_TLAST_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  typedef struct {
    int vpct;
    int rpct;
    bit cnt_mode;
    bit mid_start;
    bit exp_done;
  } scen_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_row(input string name, input int r, input logic [RB-1:0] act,
                         input logic [RB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int k = 0; k < BPR; k++) begin
        if (act[RB-1-k*IW -: IW] !== exp[RB-1-k*IW -: IW]) begin
          $display("FAIL %s row %0d beat %0d: got %0h expected %0h", name, r, k,
                   act[RB-1-k*IW -: IW], exp[RB-1-k*IW -: IW]);
          break;
        end
      end
    end
  endtask

  // Golden packer: a row is its beats concatenated in arrival order, first beat at the MSBs.
  function automatic logic [RB-1:0] model_row(input int r);
    logic [RB-1:0] v = '0;
    for (int k = 0; k < BPR; k++) v = (v << IW) | RB'(mem[r*BPR + k]);
    return v;
  endfunction

  task automatic fill_mem(input bit cnt_mode);
    for (int n = 0; n < NB; n++) begin
      if (cnt_mode) begin
        logic [IW-1:0] beat = '0;
        for (int j = 0; j < EPB; j++)
          beat = (beat << W) | IW'(16'((n / BPR) * C + (n % BPR) * EPB + j));
        mem[n] = beat;
      end else begin
        mem[n] = {$urandom, $urandom};
      end
    end
    exp_q.delete();
    for (int r = 0; r < R; r++) exp_q.push_back(model_row(r));
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("start clears matrix_done", 64'(matrix_done), 64'd0);
    chk("start s_tready", 64'(s_tready), 64'd1);
    chk("start out_valid", 64'(out_valid), 64'd0);
    chk("start out_row_idx", 64'(out_row_idx), 64'd0);
  endtask

  task automatic drive_beats(input int n0, input int n1, input int vpct, input int bad);
    int n = n0;
    int cyc = 0;
    while (n < n1 && cyc < LIMIT) begin
      @(negedge clk);
      s_tvalid = ($urandom_range(99) < vpct);
      s_tdata  = mem[n];
      s_tlast  = (n == NB - 1) != (n == bad);
      #1;
      if (s_tvalid && s_tready) n++;
      cyc++;
    end
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    if (n < n1) begin
      errors++;
      $display("FAIL drive timeout: got %0d beats expected %0d", n - n0, n1 - n0);
    end
  endtask

  task automatic check_rows(input int rpct, input bit cnt_mode);
    int r = 0;
    int cyc = 0;
    bit stall = 1'b0;
    logic [RB-1:0] hold_row = '0;
    logic [7:0] hold_idx = '0;
    while (r < R && cyc < LIMIT) begin
      @(negedge clk);
      out_ready = ($urandom_range(99) < rpct);
      #1;
      if (stall) begin
        chk("stall out_valid held", 64'(out_valid), 64'd1);
        chk("stall idx held", 64'(out_row_idx), 64'(hold_idx));
        chk_row("stall row held", r, out_row, hold_row);
      end
      stall    = out_valid && !out_ready;
      hold_row = out_row;
      hold_idx = out_row_idx;
      if (out_valid && out_ready) begin
        logic [RB-1:0] exp;
        exp = exp_q.pop_front();
        chk_row("row data", r, out_row, exp);
        chk("row idx", 64'(out_row_idx), 64'(r[7:0]));
        if (cnt_mode) chk("row MSB element", 64'(out_row[RB-1 -: W]), 64'(r * C));
        if (r == R - 1) chk("done before final handoff", 64'(matrix_done), 64'd0);
        r++;
      end
      cyc++;
    end
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    if (r < R) begin
      errors++;
      $display("FAIL rows timeout: got %0d rows expected %0d", r, R);
    end
    chk("matrix_done after final handoff", 64'(matrix_done), 64'd1);
    chk("out_valid in DONE", 64'(out_valid), 64'd0);
    chk("s_tready in DONE", 64'(s_tready), 64'd0);
    chk("no extra rows", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, " s_tready"}, 64'(s_tready), 64'd0);
    chk({tag, " out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, " out_row zero"}, 64'(|out_row), 64'd0);
    chk({tag, " out_row_idx"}, 64'(out_row_idx), 64'd0);
    chk({tag, " matrix_done"}, 64'(matrix_done), 64'd0);
    chk({tag, " err_tlast"}, 64'(err_tlast), 64'd0);
    chk({tag, " state"}, 64'(state_dbg), 64'd0);
  endtask

  initial begin
    scen_t scen [3];
    int acc;
    scen[0] = '{vpct: 100, rpct: 100, cnt_mode: 1'b1, mid_start: 1'b0, exp_done: 1'b1};
    scen[1] = '{vpct: 50,  rpct: 50,  cnt_mode: 1'b0, mid_start: 1'b0, exp_done: 1'b1};
    scen[2] = '{vpct: 80,  rpct: 35,  cnt_mode: 1'b0, mid_start: 1'b1, exp_done: 1'b1};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    reset_checks("reset");
    @(negedge clk);
    rst = 1'b0;

    // Beats offered before any start must be refused.
    s_tvalid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("idle s_tready", 64'(s_tready), 64'd0);
    chk("idle state", 64'(state_dbg), 64'd0);
    s_tvalid = 1'b0;

    for (int i = 0; i < 3; i++) begin
      fill_mem(scen[i].cnt_mode);
      pulse_start();
      fork
        drive_beats(0, NB, scen[i].vpct, -1);
        check_rows(scen[i].rpct, scen[i].cnt_mode);
        if (scen[i].mid_start) begin
          repeat (300) @(negedge clk);
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
      join
      chk("scenario err_tlast", 64'(err_tlast), 64'd0);
      chk("scenario matrix_done", 64'(matrix_done), 64'(scen[i].exp_done));
    end

    // Consumer stalled: both banks fill, then input must stall.
    fill_mem(1'b0);
    pulse_start();
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      s_tvalid = 1'b1;
      s_tdata  = mem[acc];
      s_tlast  = 1'b0;
      #1;
      if (s_tvalid && s_tready) acc++;
    end
    @(negedge clk);
    s_tvalid = 1'b0;
    #1;
    chk("backpressure beats accepted", 64'(acc), 64'd32);
    chk("backpressure s_tready", 64'(s_tready), 64'd0);
    chk("backpressure out_valid", 64'(out_valid), 64'd1);
    chk("backpressure idx", 64'(out_row_idx), 64'd0);
    fork
      drive_beats(acc, NB, 100, -1);
      check_rows(100, 1'b0);
    join

    // Wrong tlast on beat 15, then a reset in the middle of the matrix.
    fill_mem(1'b1);
    pulse_start();
    out_ready = 1'b1;
    drive_beats(0, 16, 100, 15);
    #1;
    chk("err_tlast after bad tlast", 64'(err_tlast), 64'(EXP_ERR));
    drive_beats(16, 700, 100, -1);
    #1;
    chk("err_tlast sticky", 64'(err_tlast), 64'(EXP_ERR));
    #2;
    rst = 1'b1;
    #1;
    reset_checks("async reset");
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;
    fill_mem(1'b0);
    pulse_start();
    fork
      drive_beats(0, NB, 50, -1);
      check_rows(50, 1'b0);
    join
    chk("post-reset err_tlast", 64'(err_tlast), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
